// File: rtl/counter_ctrl_if.sv
// Start/stop request and downstream-counter handshake bundle for counter_ctrl.
// Carries pause_i only when COUNTER_CTRL_PAUSE_EN is defined.
interface counter_ctrl_if #(
  parameter int REPEATS = 1
);
  localparam int RC_W = $clog2(REPEATS + 1);

  logic            start_i;
  logic            stop_i;
  logic            cnt_finished_i;
  logic            cnt_reset_o;
  logic            cnt_enable_o;
  logic            busy_o;
  logic            done_o;
  logic [RC_W-1:0] run_count_o;

`ifdef COUNTER_CTRL_PAUSE_EN
  logic            pause_i;

  modport slave (
    input  start_i, stop_i, pause_i, cnt_finished_i,
    output cnt_reset_o, cnt_enable_o, busy_o, done_o, run_count_o
  );

  modport master (
    output start_i, stop_i, pause_i, cnt_finished_i,
    input  cnt_reset_o, cnt_enable_o, busy_o, done_o, run_count_o
  );
`else
  modport slave (
    input  start_i, stop_i, cnt_finished_i,
    output cnt_reset_o, cnt_enable_o, busy_o, done_o, run_count_o
  );

  modport master (
    output start_i, stop_i, cnt_finished_i,
    input  cnt_reset_o, cnt_enable_o, busy_o, done_o, run_count_o
  );
`endif
endinterface

// File: rtl/counter_ctrl.sv
// Sequencer for the counter block: clears it, drives a prescaled enable and repeats REPEATS runs.
// Optional pause input is compiled in with COUNTER_CTRL_PAUSE_EN.
module counter_ctrl #(
  parameter int PRESCALE = 1,
  parameter int REPEATS  = 1
) (
  input  logic           clock_i,
  input  logic           reset_i,
  counter_ctrl_if.slave  bus
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int RI_W = (REPEATS > 1) ? $clog2(REPEATS) : 1;
  localparam int RC_W = $clog2(REPEATS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_reg;
  logic [PS_W-1:0] presc_reg;
  logic [RI_W-1:0] run_idx_reg;
  logic [RC_W-1:0] run_count_reg;

  logic paused;
  logic presc_last;
  logic last_run;

`ifdef COUNTER_CTRL_PAUSE_EN
  assign paused = bus.pause_i;
`else
  assign paused = 1'b0;
`endif

  assign presc_last = (presc_reg == PS_W'(PRESCALE - 1));
  assign last_run   = (run_idx_reg == RI_W'(REPEATS - 1));

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg     <= IDLE;
      presc_reg     <= '0;
      run_idx_reg   <= '0;
      run_count_reg <= '0;
    end else if (bus.stop_i && (state_reg != IDLE)) begin
      // Abort wins over everything; completed-run count is preserved.
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start_i && !bus.stop_i) begin
            state_reg     <= CLEAR;
            run_idx_reg   <= '0;
            run_count_reg <= '0;
          end
        end
        CLEAR: begin
          presc_reg <= '0;
          state_reg <= RUN;
        end
        RUN: begin
          if (bus.cnt_finished_i) begin
            run_count_reg <= run_count_reg + 1'b1;
            if (last_run) begin
              state_reg <= DONE;
            end else begin
              run_idx_reg <= run_idx_reg + 1'b1;
              state_reg   <= CLEAR;
            end
          end else if (!paused) begin
            presc_reg <= presc_last ? '0 : (presc_reg + 1'b1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Reset term keeps the downstream counter's synchronous clear asserted during reset.
  assign bus.cnt_reset_o  = reset_i | (state_reg == CLEAR);
  assign bus.cnt_enable_o = (state_reg == RUN) && presc_last && !bus.cnt_finished_i && !paused;
  assign bus.busy_o       = (state_reg != IDLE);
  assign bus.done_o       = (state_reg == DONE);
  assign bus.run_count_o  = run_count_reg;

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
Sequencer directly upstream of the team's `counter` block. It clears the counter on a start request and drives its enable with a prescaled tick. It watches the counter's finished flag, optionally repeats the run a fixed number of times, then reports completion with a one-cycle done pulse. It is the standard way for higher-level logic to launch timed waits without handling the counter handshake directly.

Parameters:
PRESCALE, 1, clocks per counter enable pulse; legal range >= 1; 1 means enable every cycle.
REPEATS, 1, counter runs per accepted start; legal range >= 1.

Ports:
clock_i  input  1  clock; all state updates on the rising edge.
reset_i  input  1  asynchronous, active-high reset.
start_i  input  1  start request; sampled only in IDLE.
stop_i  input  1  abort request; takes priority over start_i and over every state transition.
cnt_finished_i  input  1  finished flag from the downstream counter.
cnt_reset_o  output  1  synchronous clear to the counter.
cnt_enable_o  output  1  enable to the counter.
busy_o  output  1  high in every state except IDLE.
done_o  output  1  one-cycle pulse when all REPEATS runs have completed.
run_count_o  output  $clog2(REPEATS+1)  number of runs completed since the last accepted start.

Behaviour:
- Reset and synchronicity: reset_i is asynchronous and active-high. Clock is clock_i.
- Async reset values: state = IDLE, prescaler = 0, run index = 0, run_count_o = 0, done_o = 0, busy_o = 0, cnt_enable_o = 0.
- cnt_reset_o = reset_i OR (state == CLEAR). It is held high through reset so the counter's synchronous reset clears it.
- State machine: IDLE, CLEAR, RUN, DONE, in a binary-encoded state register.
- IDLE:
  - start_i=1 and stop_i=0 -> CLEAR. run_count_o and run index are zeroed at the same time.
  - Otherwise stay in IDLE.
- CLEAR: lasts exactly one cycle.
  - cnt_reset_o=1, cnt_enable_o=0, prescaler zeroed.
  - Next state is RUN.
- RUN:
  - Prescaler counts 0..PRESCALE-1 and wraps.
  - cnt_enable_o = (prescaler == PRESCALE-1) AND NOT cnt_finished_i. This is the only combinational input-to-output path.
  - On cnt_finished_i=1, run_count_o increments.
    - If run index == REPEATS-1 -> DONE.
    - Otherwise run index increments and the next state is CLEAR.
- DONE: lasts one cycle. done_o=1, then -> IDLE.
- Output decoding: done_o, busy_o and cnt_reset_o (apart from the reset term) decode from registered state only.
- stop_i=1 in CLEAR, RUN or DONE:
  - Next state is IDLE and no done_o pulse is issued.
  - run_count_o keeps the number of completed runs.
  - The counter is left as is; the next start clears it.
- start_i outside IDLE is ignored, with no queuing. start_i held high across DONE->IDLE relaunches one cycle after IDLE.
- cnt_finished_i outside RUN is ignored.
- Timing, with the counter at MAX_COUNTER_VALUE = M:
  - Each run lasts 1 CLEAR cycle + ((M+1)*PRESCALE + 1) RUN cycles.
  - done_o is high R*((M+1)*PRESCALE + 2) + 1 cycles after the edge that sampled start_i, where R = REPEATS.
- Widths:
  - Prescaler: max($clog2(PRESCALE),1) bits.
  - Run index: max($clog2(REPEATS),1) bits.
  - No arithmetic wraps in legal operation.

Optional Feature:
COUNTER_CTRL_PAUSE_EN
- Defined:
  - Adds port pause_i (input, 1 bit).
  - While pause_i=1 in RUN: prescaler frozen, cnt_enable_o=0, state held, cnt_finished_i still honoured.
  - pause_i has no effect in other states. stop_i overrides pause_i.
- Undefined: no pause_i port; behaviour is identical to pause_i tied to 0.

Test Plan:
- Single run:
  - Stimulus: PRESCALE=1, REPEATS=1, counter M=3; start_i pulsed at edge 0.
  - Response: cnt_reset_o=1 in cycle 1; cnt_enable_o=1 in cycles 2-5; done_o=1 only in cycle 7; busy_o=1 in cycles 1-7; run_count_o=1.
- Prescaled run:
  - Stimulus: PRESCALE=4, M=3.
  - Response: cnt_enable_o high once every 4 cycles, 4 pulses total; done_o in cycle 19.
- Repeated runs:
  - Stimulus: REPEATS=3, PRESCALE=1, M=3.
  - Response: three cnt_reset_o pulses in cycles 1, 7 and 13; run_count_o steps 1, 2, 3; single done_o in cycle 19.
- Abort mid-RUN:
  - Stimulus: stop_i=1 in cycle 4 of the single-run setup.
  - Response: IDLE in cycle 5, no done_o, run_count_o=0; a fresh start then completes normally.
- Start handling:
  - Stimulus: start_i and stop_i both high in IDLE.
  - Response: stays in IDLE.
  - Stimulus: start_i pulsed again while busy.
  - Response: ignored; exactly one done_o.
- Async reset mid-RUN:
  - Stimulus: reset_i asserted mid-RUN, between clock edges.
  - Response: outputs go to reset values immediately; cnt_reset_o=1 while reset_i is high; counter reads 0 after the next edge.
  - With COUNTER_CTRL_PAUSE_EN: pause_i=1 for 10 cycles in RUN delays done_o by exactly 10 cycles.
